matrix_addsub_seq: RTL and testbench

MATRIX_ADDSUB_SEQ -- requirements
Module: matrix_addsub_seq

---
 rtl/matrix_addsub_seq.sv | 135 +++++++++++++
 tb/tb_matrix_addsub_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_addsub_seq.sv
// Sequential signed element-wise matrix add/subtract, LANES elements per clock.
// Define MATRIX_ADDSUB_SAT_EN to saturate overflowing elements instead of wrapping.
//   state | meaning
//   IDLE  | waiting for start; result_out and overflow hold
//   RUN   | one chunk of LANES elements written per clock
//   DONE  | single-cycle done pulse, then back to IDLE
module matrix_addsub_seq #(
    parameter int DATA_W = 8,
    parameter int DIM    = 5,
    parameter int LANES  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       op_sub,
    input  logic [DIM*DIM*DATA_W-1:0]  matrix_A,
    input  logic [DIM*DIM*DATA_W-1:0]  matrix_B,
    output logic [DIM*DIM*DATA_W-1:0]  result_out,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    localparam int N  = DIM * DIM;
    localparam int P  = (N + LANES - 1) / LANES;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int XW = $clog2(N + LANES) + 1;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [N*DATA_W-1:0] a_q, b_q;
    logic                sub_q;
    logic [CW-1:0]       cnt_q;
    logic [XW-1:0]       base_q;
    logic [DATA_W-1:0]   res_q [N];
    logic                ovf_q, busy_q, done_q;

    logic [DATA_W-1:0]   a_el [N];
    logic [DATA_W-1:0]   b_el [N];
    logic [XW-1:0]       lane_pos [LANES];
    logic [IW-1:0]       lane_idx [LANES];
    logic [DATA_W:0]     lane_sum [LANES];
    logic [DATA_W-1:0]   lane_a [LANES];
    logic [DATA_W-1:0]   lane_b [LANES];
    logic [DATA_W-1:0]   lane_res_d [LANES];
    logic [LANES-1:0]    lane_vld;
    logic [LANES-1:0]    lane_ovf_d;
    logic                last_chunk;

    genvar g;
    for (g = 0; g < N; g++) begin : g_elem
        assign a_el[g] = a_q[g*DATA_W +: DATA_W];
        assign b_el[g] = b_q[g*DATA_W +: DATA_W];
        assign result_out[g*DATA_W +: DATA_W] = res_q[g];
    end

    // Lanes past the end of the matrix in the final chunk are masked by lane_vld.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_pos[l]   = base_q + XW'(l);
            lane_vld[l]   = lane_pos[l] < XW'(N);
            lane_idx[l]   = lane_vld[l] ? lane_pos[l][IW-1:0] : '0;
            lane_a[l]     = a_el[lane_idx[l]];
            lane_b[l]     = b_el[lane_idx[l]];
            lane_sum[l]   = sub_q ? ({lane_a[l][DATA_W-1], lane_a[l]} - {lane_b[l][DATA_W-1], lane_b[l]})
                                  : ({lane_a[l][DATA_W-1], lane_a[l]} + {lane_b[l][DATA_W-1], lane_b[l]});
            lane_ovf_d[l] = (sub_q ? (lane_a[l][DATA_W-1] != lane_b[l][DATA_W-1])
                                   : (lane_a[l][DATA_W-1] == lane_b[l][DATA_W-1]))
                            && (lane_sum[l][DATA_W-1] != lane_a[l][DATA_W-1]);
`ifdef MATRIX_ADDSUB_SAT_EN
            lane_res_d[l] = lane_ovf_d[l] ? (lane_sum[l][DATA_W] ? MINV : MAXV)
                                          : lane_sum[l][DATA_W-1:0];
`else
            lane_res_d[l] = lane_sum[l][DATA_W-1:0];
`endif
        end
    end

    assign last_chunk = (cnt_q == CW'(P - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            base_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < N; i++) res_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= matrix_A;
                        b_q     <= matrix_B;
                        sub_q   <= op_sub;
                        cnt_q   <= '0;
                        base_q  <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_vld[l]) res_q[lane_idx[l]] <= lane_res_d[l];
                    end
                    ovf_q  <= ovf_q | (|(lane_vld & lane_ovf_d));
                    cnt_q  <= cnt_q + 1'b1;
                    base_q <= base_q + XW'(LANES);
                    if (last_chunk) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Scoreboard bench for matrix_addsub_seq: default build plus a LANES=4 instance.
module tb_matrix_addsub_seq;

    localparam int W    = 8;
    localparam int DIM  = 5;
    localparam int N    = DIM * DIM;
    localparam int NW   = N * W;
    localparam int P    = 5;
    localparam int P4   = 7;
    localparam int MAXI = 127;
    localparam int MINI = -128;

    typedef struct {
        logic [NW-1:0] res;
        logic          ovf;
    } exp_t;

    logic          clk, rst;
    logic          start, op_sub;
    logic [NW-1:0] mA, mB, res;
    logic          ovf, busy, done;
    logic          s4, sub4;
    logic [NW-1:0] A4, B4, res4;
    logic          ovf4, busy4, done4;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    matrix_addsub_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
        .matrix_A(mA), .matrix_B(mB), .result_out(res),
        .overflow(ovf), .busy(busy), .done(done)
    );

    matrix_addsub_seq #(.DATA_W(W), .DIM(DIM), .LANES(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .op_sub(sub4),
        .matrix_A(A4), .matrix_B(B4), .result_out(res4),
        .overflow(ovf4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [NW-1:0] a, input logic [NW-1:0] b, input logic sub);
        exp_t e;
        int av, bv, t;
        logic [W-1:0] r;
        e.res = '0;
        e.ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            av = $signed(a[i*W +: W]);
            bv = $signed(b[i*W +: W]);
            t  = sub ? av - bv : av + bv;
            r  = t[W-1:0];
            if (t > MAXI || t < MINI) begin
                e.ovf = 1'b1;
`ifdef MATRIX_ADDSUB_SAT_EN
                r = (t > 0) ? W'(MAXI) : W'(MINI);
`endif
            end
            e.res[i*W +: W] = r;
        end
        return e;
    endfunction

    function automatic logic [NW-1:0] fill(input int v);
        logic [NW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v[W-1:0];
        return r;
    endfunction

    function automatic logic [NW-1:0] set_el(input logic [NW-1:0] m, input int idx, input int v);
        logic [NW-1:0] r;
        r = m;
        r[idx*W +: W] = v[W-1:0];
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            chk("sb_pending", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_result", res, e.res);
                chk("sb_overflow", ovf, e.ovf);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [NW-1:0] a, input logic [NW-1:0] b, input logic sub);
        int cyc, bz;
        exp_t e;
        mA = a; mB = b; op_sub = sub; start = 1'b1;
        @(posedge clk);
        e = model(a, b, sub);
        sb_q.push_back(e);
        #1;
        start = 1'b0;
        mA = ~a; mB = ~b; op_sub = ~sub;
        cyc = 0; bz = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) bz++;
        end while (!done && cyc < 40);
        chk("done_latency", cyc - 1, P);
        chk("busy_cycles", bz, P);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("result_hold", res, e.res);
    endtask

    initial begin
        logic [NW-1:0] ra, rb;
        exp_t e4;
        int cyc, bz, dn, first_dn;
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; mA = '0; mB = '0;
        s4 = 1'b0; sub4 = 1'b0; A4 = '0; B4 = '0;
        @(negedge clk);
        chk("rst_result", res, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        run_op(fill(10), fill(20), 1'b0);
        chk("add_30_el12", res[12*W +: W], 30);

        run_op(set_el(fill(0), 0, 100), set_el(fill(0), 0, 50), 1'b0);
`ifdef MATRIX_ADDSUB_SAT_EN
        chk("add_ovf_el0", res[0 +: W], 8'h7F);
`else
        chk("add_ovf_el0", res[0 +: W], 8'h96);
`endif
        chk("add_ovf_flag", ovf, 1);

        run_op(set_el(fill(0), 24, -100), set_el(fill(0), 24, 50), 1'b1);
`ifdef MATRIX_ADDSUB_SAT_EN
        chk("sub_ovf_el24", res[24*W +: W], 8'h80);
`else
        chk("sub_ovf_el24", res[24*W +: W], 8'h6A);
`endif
        chk("sub_ovf_flag", ovf, 1);

        run_op(fill(5), fill(-3), 1'b1);
        chk("clean_clears_ovf", ovf, 0);
        chk("clean_el0", res[0 +: W], 8);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                ra[i*W +: W] = W'($urandom_range(0, 255));
                rb[i*W +: W] = W'($urandom_range(0, 255));
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        // Abort in the 3rd RUN cycle; nothing is queued so any done is spurious.
        mA = fill(7); mB = fill(7); op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_result", res, 0);
        chk("abort_overflow", ovf, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(fill(-4), fill(9), 1'b1);

        A4 = fill(1); B4 = fill(1); sub4 = 1'b0; s4 = 1'b1;
        @(posedge clk);
        #1 s4 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done4 && cyc < 40);
        chk("lanes4_done_latency", cyc - 1, P4);
        e4 = model(fill(1), fill(1), 1'b0);
        chk("lanes4_result", res4, e4.res);
        @(negedge clk);

        // Start held high: the second request may only land once the FSM is back in IDLE.
        A4 = fill(3); B4 = fill(3); s4 = 1'b1;
        @(posedge clk);
        bz = 0; dn = 0; first_dn = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 9) begin
                if (busy4) bz++;
                if (done4) begin
                    dn++;
                    if (first_dn == 0) first_dn = k;
                end
            end
            if (k == 7) begin
                chk("lanes4_el23_written", res4[23*W +: W], 6);
                chk("lanes4_el24_held", res4[24*W +: W], 2);
            end
            if (k == 10) begin
                chk("lanes4_reaccept", busy4, 1);
                s4 = 1'b0;
            end
        end
        chk("lanes4_busy_cycles", bz, P4);
        chk("lanes4_done_count", dn, 1);
        chk("lanes4_done_cycle", first_dn, P4 + 1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done4 && cyc < 40);
        chk("lanes4_second_done", done4, 1);
        e4 = model(fill(3), fill(3), 1'b0);
        chk("lanes4_second_result", res4, e4.res);
        chk("lanes4_overflow", ovf4, e4.ovf);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
